// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode hex digits with double-buffered, tear-free updates.
// Optional LEADING_ZERO_BLANK_EN: auto-blank leading zero digits (digit 0 and dp-marked digits exempt).
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  wrap;

    logic [DATA_W-1:0]     shadow_data;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [DATA_W-1:0]     active_data;
    logic [NUM_DIGITS-1:0] active_dp;
    logic [NUM_DIGITS-1:0] active_blank;

    logic [NUM_DIGITS-1:0] blank_eff;
    logic [NUM_DIGITS-1:0] an_next;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h72;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Refresh divider and digit scan index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + CNT_W'(1);
            frame_start <= wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Double buffer: shadow captures loads, active only changes at a frame wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '0;
            pending      <= 1'b0;
        end else begin
            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (wrap && pending) begin
                active_data  <= shadow_data;
                active_dp    <= shadow_dp;
                active_blank <= shadow_blank;
            end
            // A load on the wrap edge keeps pending set so its data shows one frame later
            if (load) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Leading-zero run from the top digit; a dp digit ends the run
    always_comb begin
        zero_run  = 1'b1;
        blank_eff = active_blank;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (active_data[4*k +: 4] == 4'h0) && !active_dp[k];
            if ((k != 0) && zero_run) begin
                blank_eff[k] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        blank_eff = active_blank;
    end
`endif

    // Select the digit addressed by idx
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib    = active_data[4*k +: 4];
                cur_dp     = active_dp[k];
                cur_blank  = blank_eff[k];
                an_next[k] = 1'b0;
            end
        end
    end

    // Registered pin drivers; a blanked slot keeps its anode on for even duty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= cur_blank ? 7'h7F : hex_to_seg(cur_nib);
            dp  <= cur_blank | ~cur_dp;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (4 digits, 4 cycles per slot).
module tb_hex_display_scanner;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpm;
        logic [3:0]  blank;
        logic [27:0] exp_seg;
        logic [3:0]  exp_dpn;
    } vec_t;

    typedef struct {
        int          due;
        logic [27:0] seg;
        logic [3:0]  dpn;
    } disp_t;

    logic        clk;
    logic        resetn;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        pending;

    int          checks;
    int          errors;
    int          frame_no;
    logic        p0;
    logic [27:0] cur_seg;
    logic [3:0]  cur_dpn;
    disp_t       sb_q[$];
    vec_t        tbl[6];
    vec_t        none_v;
    vec_t        v1234;
    vec_t        v1111;
    vec_t        v6bd9;
    logic [27:0] zero_seg;

    hex_display_scanner #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mkv(input logic [15:0] d, input logic [3:0] dpm, input logic [3:0] bl,
                                 input logic [27:0] es, input logic [3:0] edpn);
        vec_t v;
        v.data    = d;
        v.dpm     = dpm;
        v.blank   = bl;
        v.exp_seg = es;
        v.exp_dpn = edpn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One 16-cycle frame: compare every sample, optionally load at up to two slots
    task automatic run_frame(input int sa, input vec_t va, input int sb, input vec_t vb);
        int         d;
        logic [3:0] aexp;
        logic       pexp;
        disp_t      e;
        while (sb_q.size() > 0 && sb_q[0].due <= frame_no) begin
            cur_seg = sb_q[0].seg;
            cur_dpn = sb_q[0].dpn;
            void'(sb_q.pop_front());
        end
        pexp = p0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            d    = j / 4;
            aexp = ~(4'b0001 << d);
            if (j == 15) begin
                pexp = (sa == 14) || (sb == 14);
            end else begin
                pexp = p0 || (sa >= 0 && sa < j) || (sb >= 0 && sb < j);
            end
            chk($sformatf("an f%0d s%0d", frame_no, j), 32'(an), 32'(aexp));
            chk($sformatf("seg f%0d s%0d", frame_no, j), 32'(seg), 32'(cur_seg[d*7 +: 7]));
            chk($sformatf("dp f%0d s%0d", frame_no, j), 32'(dp), 32'(cur_dpn[d]));
            chk($sformatf("frame_start f%0d s%0d", frame_no, j), 32'(frame_start), 32'(j == 15));
            chk($sformatf("pending f%0d s%0d", frame_no, j), 32'(pending), 32'(pexp));
            if (j == sa || j == sb) begin
                e = '{due: frame_no + ((j == 14) ? 2 : 1),
                      seg: (j == sa) ? va.exp_seg : vb.exp_seg,
                      dpn: (j == sa) ? va.exp_dpn : vb.exp_dpn};
                sb_q.push_back(e);
                load     = 1'b1;
                data_in  = (j == sa) ? va.data : vb.data;
                dp_in    = (j == sa) ? va.dpm : vb.dpm;
                blank_in = (j == sa) ? va.blank : vb.blank;
            end else begin
                load = 1'b0;
            end
        end
        p0 = pexp;
        frame_no++;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        frame_no = 0;
        p0       = 1'b0;
        resetn   = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        blank_in = '0;

`ifdef LEADING_ZERO_BLANK_EN
        zero_seg = {7'h7F, 7'h7F, 7'h7F, 7'h01};
        tbl[2]   = mkv(16'h0040, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h4C, 7'h01}, 4'b1111);
        tbl[3]   = mkv(16'h0000, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111);
        tbl[4]   = mkv(16'h0005, 4'b0010, 4'b0000, {7'h7F, 7'h7F, 7'h01, 7'h24}, 4'b1101);
`else
        zero_seg = {7'h01, 7'h01, 7'h01, 7'h01};
        tbl[2]   = mkv(16'h0040, 4'b0000, 4'b0000, {7'h01, 7'h01, 7'h4C, 7'h01}, 4'b1111);
        tbl[3]   = mkv(16'h0000, 4'b0000, 4'b0000, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b1111);
        tbl[4]   = mkv(16'h0005, 4'b0010, 4'b0000, {7'h01, 7'h01, 7'h01, 7'h24}, 4'b1101);
`endif
        tbl[0] = mkv(16'hA5C3, 4'b0010, 4'b0000, {7'h08, 7'h24, 7'h72, 7'h06}, 4'b1101);
        tbl[1] = mkv(16'h8888, 4'b0000, 4'b1000, {7'h7F, 7'h00, 7'h00, 7'h00}, 4'b1111);
        tbl[5] = mkv(16'hF9E7, 4'b1111, 4'b0100, {7'h38, 7'h7F, 7'h30, 7'h0F}, 4'b0100);
        v1234  = mkv(16'h1234, 4'b0000, 4'b0000, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111);
        v1111  = mkv(16'h1111, 4'b0000, 4'b0000, {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b1111);
        v6bd9  = mkv(16'h6BD9, 4'b0000, 4'b0000, {7'h20, 7'h60, 7'h42, 7'h04}, 4'b1111);
        none_v = mkv(16'h0000, 4'b0000, 4'b0000, 28'h0, 4'b1111);
        cur_seg = zero_seg;
        cur_dpn = 4'b1111;

        repeat (3) @(negedge clk);
        chk("reset an", 32'(an), 32'h0000000F);
        chk("reset seg", 32'(seg), 32'h0000007F);
        chk("reset dp", 32'(dp), 32'h00000001);
        chk("reset frame_start", 32'(frame_start), 32'h0);
        chk("reset pending", 32'(pending), 32'h0);
        resetn = 1'b1;

        run_frame(-1, none_v, -1, none_v);
        for (int i = 0; i < 6; i++) begin
            run_frame(5, tbl[i], -1, none_v);
        end
        // Load on the wrap edge: held back a full frame
        run_frame(14, v1234, -1, none_v);
        run_frame(-1, none_v, -1, none_v);
        // Back-to-back loads: last one wins
        run_frame(3, v1111, 4, v6bd9);
        // Overwrite while pending
        run_frame(2, v1111, 9, tbl[0]);
        run_frame(-1, none_v, -1, none_v);

        // Reset asserted mid-slot with a load in flight
        load    = 1'b1;
        data_in = 16'h1234;
        @(posedge clk);
        #1;
        chk("pre-reset pending", 32'(pending), 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        chk("midreset an", 32'(an), 32'h0000000F);
        chk("midreset seg", 32'(seg), 32'h0000007F);
        chk("midreset dp", 32'(dp), 32'h1);
        chk("midreset pending", 32'(pending), 32'h0);
        chk("midreset frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        resetn   = 1'b1;
        frame_no = 0;
        p0       = 1'b0;
        sb_q.delete();
        cur_seg  = zero_seg;
        cur_dpn  = 4'b1111;
        run_frame(-1, none_v, -1, none_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Parametrised, time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Holds a hex value per digit in double-buffered registers and decodes one digit at a time.
- Scans digit anodes at a programmable refresh rate and swaps new data in only at frame boundaries, so the display never tears.
- Sits between datapath status registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range >= 1, where 1 advances every cycle.
- CNT_W, 16, width of the refresh counter; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_in into the shadow buffer.
- data_in  in  4*NUM_DIGITS  nibble k at [4k+3:4k] is digit k; digit 0 is rightmost/least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- blank_in  in  NUM_DIGITS  force digit dark; 1 = blank.
- an  out  NUM_DIGITS  anode enables, active-low; exactly one bit is 0 when a digit is shown.
- seg  out  7  segments {a,b,c,d,e,f,g} on seg[6:0], active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.
- pending  out  1  high while the shadow buffer holds data not yet transferred to the active buffer.

Behaviour:
- Reset (asynchronous, resetn=0): div counter=0, idx=0, shadow and active buffers=0, pending=0, an=all 1, seg=7'h7F, dp=1, frame_start=0.
- Refresh counter: counts 0..REFRESH_DIV-1.
  - tick is asserted in the cycle the counter equals REFRESH_DIV-1; the counter returns to 0 on the next edge.
- Digit index: on a tick edge, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Frame wrap (tick && idx==NUM_DIGITS-1):
  - frame_start is registered high for the following cycle.
  - If pending=1, active <= shadow and pending <= 0.
- load:
  - Shadow is written at the edge where load=1, and pending <= 1.
  - A load on the wrap cycle writes shadow. Active takes the pre-edge shadow content, and pending stays 1 so the new data appears next frame.
  - Back-to-back loads: last one wins.
  - load while pending=1 overwrites shadow; no error is raised.
- Outputs are registered and are functions of the current idx and active buffer, so they lag an idx change by 1 cycle.
  - First digit 0 display appears the cycle after reset release.
- Segment decode, hex to seg, 0..F:
  - 0..7: 01,4F,12,06,4C,24,20,0F
  - 8..F: 00,04,08,60,72,42,30,38
- Blanked digit (blank bit set): the anode bit is still driven low for its slot (constant brightness duty), with seg=7F and dp=1.
- dp = ~active_dp[idx] unless blanked.
- NUM_DIGITS=1: idx is constant 0, and every tick is a frame wrap.
- Reset asserted mid-scan or with load high: all state returns to reset values immediately; the load is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit k whose nibble is 0 and whose higher-index nibbles are all 0 is treated as blanked.
  - Digit 0 is never auto-blanked, so a value of 0 shows "0".
  - Computed from the active buffer, combined OR with blank_in bits.
  - A digit with its dp bit set is exempt, so "0.5" is displayed intact.
- Undefined: only blank_in controls blanking, and zeros display normally.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset release, no load → an cycles 1110,1101,1011,0111 with 4 cycles per digit; seg=01 every slot; frame_start pulses once per 16 cycles.
- load with data_in=16'hA5C3, dp_in=4'b0010, blank_in=0 mid-frame:
  - pending=1 until the next wrap, display unchanged until then.
  - Next frame shows seg 06,72,24,08 for digits 0..3; dp=0 only in digit 1's slot.
- load asserted on the exact wrap cycle with 16'h1234 → not shown in the coming frame; pending stays 1; shown in the frame after.
- blank_in=4'b1000, data 16'h8888 → digit 3 slot: an=0111, seg=7F, dp=1; other digits seg=00.
- With LEADING_ZERO_BLANK_EN, data 16'h0040:
  - Digits 3 and 2 show seg=7F; digit 1 shows 4C; digit 0 shows 01.
  - Data 16'h0000 → only digit 0 lit, showing 01.
- Assert resetn=0 mid-slot after a load → an=1111, seg=7F, pending=0 the same cycle; after release, the display shows zeros.
